delay_lag_estimator: RTL and testbench

//   Measures the delay of a data stream relative to a reference: finds lag L

---
 rtl/delay_lag_estimator.sv | 110 +++++++++++
 tb/tb_delay_lag_estimator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_lag_estimator.sv
// Lag estimator: scans candidate lags 0..2^DELAY_BITS-1 of a reference history
// and reports the smallest lag at which the delayed stream matches MATCH_COUNT times in a row.
module delay_lag_estimator #(
    parameter int DATA_BITS   = 32,
    parameter int DELAY_BITS  = 4,
    parameter int MATCH_COUNT = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  START,
    input  logic [DATA_BITS-1:0]  REF_VALUE,
    input  logic [DATA_BITS-1:0]  DLY_VALUE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FOUND,
    output logic [DELAY_BITS-1:0] LAG
);
    localparam int F  = 2**DELAY_BITS - 1;
    localparam int MW = $clog2(MATCH_COUNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SCAN, S_DONE} state_t;

    state_t                state;
    logic [DATA_BITS-1:0]  hist [F];
    logic [DATA_BITS-1:0]  tap;
    logic [DELAY_BITS-1:0] fill_cnt;
    logic [DELAY_BITS-1:0] lag_cur;
    logic [MW-1:0]         match_cnt;

    // Reference history advances on every CE edge regardless of FSM state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int k = 0; k < F; k++) hist[k] <= '0;
        end else if (CE) begin
            hist[0] <= REF_VALUE;
            for (int k = 1; k < F; k++) hist[k] <= hist[k-1];
        end
    end

    always_comb begin
        tap = REF_VALUE;
        for (int k = 1; k <= F; k++)
            if (lag_cur == DELAY_BITS'(k)) tap = hist[k-1];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FOUND     <= 1'b0;
            LAG       <= '0;
            fill_cnt  <= '0;
            lag_cur   <= '0;
            match_cnt <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state     <= S_FILL;
                        BUSY      <= 1'b1;
                        FOUND     <= 1'b0;
                        LAG       <= '0;
                        fill_cnt  <= '0;
                        lag_cur   <= '0;
                        match_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (CE) begin
                        if (fill_cnt == DELAY_BITS'(F - 1)) state <= S_SCAN;
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (CE) begin
                        if (tap == DLY_VALUE) begin
                            if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                                state     <= S_DONE;
                                BUSY      <= 1'b0;
                                DONE      <= 1'b1;
                                FOUND     <= 1'b1;
                                LAG       <= lag_cur;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            // Last lag failed: give up rather than wrapping the lag counter.
                            if (lag_cur == DELAY_BITS'(F)) begin
                                state <= S_DONE;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                                FOUND <= 1'b0;
                                LAG   <= '0;
                            end else begin
                                lag_cur <= lag_cur + 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_lag_estimator.sv
// Scoreboard bench for delay_lag_estimator: expected results are queued at START
// and checked when DONE pulses.
module tb_delay_lag_estimator;
    localparam int F  = 15;
    localparam int MC = 8;

    logic        CLK = 1'b0;
    logic        RESET, CE, START;
    logic [31:0] REF_VALUE, DLY_VALUE;
    logic        BUSY, DONE, FOUND;
    logic [3:0]  LAG;

    delay_lag_estimator #(.DATA_BITS(32), .DELAY_BITS(4), .MATCH_COUNT(MC)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .START(START),
        .REF_VALUE(REF_VALUE), .DLY_VALUE(DLY_VALUE),
        .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND), .LAG(LAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       found;
        bit [3:0] lag;
        int       lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_cnt;
    int          mode;     // 0: DLY = REF delayed dly_d, 1: DLY constant garbage, 2: both 7
    int          dly_d;
    bit          ce_tog;

    function automatic void drive_stream();
        REF_VALUE = (mode == 2) ? 32'd7 : ref_cnt;
        DLY_VALUE = (mode == 1) ? 32'hDEADBEEF :
                    (mode == 2) ? 32'd7 : ref_cnt - 32'(dly_d);
    endfunction

    // One clock; inputs change 1ns after the edge, counter advances only on CE edges.
    task automatic step();
        @(posedge CLK);
        #1;
        if (CE) ref_cnt = ref_cnt + 32'd1;
        CE = ce_tog ? ~CE : 1'b1;
        drive_stream();
    endtask

    task automatic start_meas(input exp_t e);
        START = 1'b1;
        step();
        START = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input int budget, inout int lat, output bit seen, output bit busy_ok);
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < budget) begin
            step();
            lat++;
            if (DONE === 1'b1) seen = 1'b1;
            else if (BUSY !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        mode = 0; dly_d = 0; ce_tog = 0; ref_cnt = 32'd100;
        CE = 1'b1; START = 1'b1; RESET = 1'b0;
        drive_stream();
        step();
        step();
        RESET = 1'b1; START = 1'b0;
        n_cmp++;
        if ({BUSY, DONE, FOUND, LAG} !== 7'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b found=%b lag=%0d, want all 0", BUSY, DONE, FOUND, LAG);
        end
        step();
    endtask

    task automatic run_one(input string name, input int m, input int d, input bit tog,
                           input exp_t e, input int budget);
        int   lat;
        bit   seen, bok;
        exp_t x;
        mode = m; dly_d = d; ce_tog = 0; CE = 1'b1;
        drive_stream();
        ce_tog = tog;
        start_meas(e);
        n_cmp++;
        if (FOUND !== 1'b0 || LAG !== 4'd0 || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL %s start: found=%b lag=%0d busy=%b, want 0 0 1", name, FOUND, LAG, BUSY);
        end
        lat = 0;
        wait_done(budget, lat, seen, bok);
        x = sbq.pop_front();
        n_cmp++;
        if (!seen || FOUND !== x.found || LAG !== x.lag || lat != x.lat) begin
            n_err++;
            $display("FAIL %s d=%0d: done=%b found=%b lag=%0d lat=%0d, want found=%b lag=%0d lat=%0d",
                     name, d, seen, FOUND, LAG, lat, x.found, x.lag, x.lat);
        end
        n_cmp++;
        if (!bok) begin
            n_err++;
            $display("FAIL %s busy: dropped before DONE, want 1 throughout", name);
        end
        ce_tog = 0; CE = 1'b1;
        step();
        n_cmp++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse: done=%b busy=%b after pulse, want 0 0", name, DONE, BUSY);
        end
    endtask

    task automatic test_sweep();
        for (int d = 0; d <= 15; d++)
            run_one("sweep", 0, d, 1'b0, '{1'b1, 4'(d), F + d + MC}, 80);
        step();
        step();
        n_cmp++;
        if (FOUND !== 1'b1 || LAG !== 4'd15) begin
            n_err++;
            $display("FAIL hold: found=%b lag=%0d in idle, want 1 15", FOUND, LAG);
        end
    endtask

    task automatic test_not_found();
        run_one("notfound", 1, 0, 1'b0, '{1'b0, 4'd0, 31}, 80);
    endtask

    task automatic test_ce_gating();
        run_one("cegate", 0, 5, 1'b1, '{1'b1, 4'd5, 2 * (F + 5 + MC)}, 150);
    endtask

    task automatic test_constant();
        run_one("const", 2, 0, 1'b0, '{1'b1, 4'd0, F + MC}, 80);
    endtask

    task automatic test_abort();
        int   lat;
        bit   seen, bok, dseen;
        exp_t x;
        // START re-asserted mid-SCAN must not disturb the running measurement.
        mode = 0; dly_d = 3; ce_tog = 0; CE = 1'b1;
        drive_stream();
        start_meas('{1'b1, 4'd3, F + 3 + MC});
        for (int i = 0; i < 19; i++) step();
        START = 1'b1;
        step();
        START = 1'b0;
        lat = 20;
        wait_done(80, lat, seen, bok);
        x = sbq.pop_front();
        n_cmp++;
        if (!seen || FOUND !== x.found || LAG !== x.lag || lat != x.lat) begin
            n_err++;
            $display("FAIL restart: done=%b found=%b lag=%0d lat=%0d, want found=%b lag=%0d lat=%0d",
                     seen, FOUND, LAG, lat, x.found, x.lag, x.lat);
        end
        step();
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL restart idle: busy=%b, want 0 (no queued start)", BUSY);
        end
        // Reset in SCAN aborts silently.
        dly_d = 4;
        drive_stream();
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 18; i++) step();
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        n_cmp++;
        if ({BUSY, DONE, FOUND, LAG} !== 7'd0) begin
            n_err++;
            $display("FAIL abort: busy=%b done=%b found=%b lag=%0d, want all 0", BUSY, DONE, FOUND, LAG);
        end
        dseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (DONE !== 1'b0 || BUSY !== 1'b0) dseen = 1'b1;
        end
        n_cmp++;
        if (dseen) begin
            n_err++;
            $display("FAIL abort idle: activity after reset abort, want none");
        end
        run_one("afterabort", 0, 2, 1'b0, '{1'b1, 4'd2, F + 2 + MC}, 80);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_not_found();
        test_ce_gating();
        test_constant();
        test_abort();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
